// File: rtl/strategy_cfg_loader.sv
// strategy_cfg_loader: framed byte-stream command parser feeding a shadow
// configuration bank. The shadow is committed atomically to the mux outputs while
// the strategy FSM is idle.
// Optional feature macro STRATEGY_CFG_CHECKSUM_EN: when defined, each frame ends
// with a CHK byte that is verified.
module strategy_cfg_loader #(
  parameter int NUM_PAR     = 8,
  parameter int PAR_W       = 16,
  parameter int NUM_STRAT   = 5,
  parameter int TIMEOUT_CYC = 100000
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic [7:0]               rx_data,
  input  logic                     rx_valid,
  input  logic                     fsm_idle,
  output logic [7:0]               strategy_sel,
  output logic [NUM_PAR*PAR_W-1:0] par_flat,
  output logic                     commit_pulse,
  output logic                     pending,
  output logic                     resp_valid,
  output logic [7:0]               resp_code
);

`ifdef STRATEGY_CFG_CHECKSUM_EN
  localparam bit HAS_CHK = 1'b1;
`else
  localparam bit HAS_CHK = 1'b0;
`endif

  localparam int TO_W = $clog2(TIMEOUT_CYC + 1);

  localparam logic [7:0] RC_OK      = 8'h00;
  localparam logic [7:0] RC_CHK     = 8'h01;
  localparam logic [7:0] RC_CMD     = 8'h02;
  localparam logic [7:0] RC_RANGE   = 8'h03;
  localparam logic [7:0] RC_TIMEOUT = 8'h04;
  localparam logic [7:0] RC_STRAT   = 8'h05;

  typedef enum logic [2:0] {
    S_IDLE, S_CMD, S_ADDR, S_LEN, S_DATA, S_CHK
  } state_t;

  state_t                   state_q, state_d;
  logic [7:0]               cmd_q, cmd_d, addr_q, addr_d, len_q, len_d;
  logic [7:0]               cnt_q, cnt_d, chk_q, chk_d;
  logic [7:0]               sel_stage_q, sel_stage_d;
  logic [TO_W-1:0]          to_cnt_q, to_cnt_d;
  logic [PAR_W-1:0]         stage_q [NUM_PAR];
  logic [PAR_W-1:0]         stage_d [NUM_PAR];
  logic [NUM_PAR-1:0]       mask_q, mask_d;
  logic [PAR_W-1:0]         shadow_q [NUM_PAR];
  logic [PAR_W-1:0]         shadow_d [NUM_PAR];
  logic [7:0]               shadow_sel_q, shadow_sel_d;
  logic [7:0]               act_sel_q, act_sel_d;
  logic [NUM_PAR*PAR_W-1:0] act_par_q, act_par_d;
  logic                     commit_q, commit_d, pending_q, pending_d;
  logic                     resp_valid_q, resp_valid_d;
  logic [7:0]               resp_code_q, resp_code_d;

  logic       frame_end, timeout, chk_ok, apply;
  logic [7:0] code;
  logic [8:0] end_sum;

  // Parser: the *_d values include the byte accepted this cycle, so a frame
  // that ends on a data byte can be evaluated without an extra cycle.
  always_comb begin
    state_d     = state_q;
    cmd_d       = cmd_q;
    addr_d      = addr_q;
    len_d       = len_q;
    cnt_d       = cnt_q;
    chk_d       = chk_q;
    sel_stage_d = sel_stage_q;
    to_cnt_d    = to_cnt_q;
    stage_d     = stage_q;
    mask_d      = mask_q;
    frame_end   = 1'b0;
    timeout     = 1'b0;
    chk_ok      = 1'b1;

    if (state_q == S_IDLE || rx_valid) begin
      to_cnt_d = '0;
    end else if (to_cnt_q == TO_W'(TIMEOUT_CYC - 1)) begin
      timeout = 1'b1;
    end else begin
      to_cnt_d = to_cnt_q + TO_W'(1);
    end

    if (rx_valid) begin
      case (state_q)
        S_IDLE: begin
          if (rx_data == 8'hA5) begin
            state_d     = S_CMD;
            chk_d       = '0;
            cnt_d       = '0;
            sel_stage_d = '0;
            mask_d      = '0;
            stage_d     = '{default: '0};
          end
        end
        S_CMD: begin
          cmd_d   = rx_data;
          chk_d   = chk_q ^ rx_data;
          state_d = S_ADDR;
        end
        S_ADDR: begin
          addr_d  = rx_data;
          chk_d   = chk_q ^ rx_data;
          state_d = S_LEN;
        end
        S_LEN: begin
          len_d = rx_data;
          chk_d = chk_q ^ rx_data;
          if (rx_data != 8'd0) begin
            state_d = S_DATA;
          end else if (HAS_CHK) begin
            state_d = S_CHK;
          end else begin
            state_d   = S_IDLE;
            frame_end = 1'b1;
          end
        end
        S_DATA: begin
          chk_d = chk_q ^ rx_data;
          cnt_d = cnt_q + 8'd1;
          if (cnt_q == 8'd0) sel_stage_d = rx_data;
          // Bytes past the staging buffer are counted only; the range check rejects the frame.
          if (cnt_q < 8'(2 * NUM_PAR)) begin
            for (int k = 0; k < NUM_PAR; k++) begin
              if (cnt_q[7:1] == 7'(k)) begin
                if (cnt_q[0]) begin
                  stage_d[k][7:0] = rx_data;
                  mask_d[k]       = 1'b1;
                end else begin
                  stage_d[k][PAR_W-1 -: 8] = rx_data;
                end
              end
            end
          end
          if (cnt_q == len_q - 8'd1) begin
            if (HAS_CHK) begin
              state_d = S_CHK;
            end else begin
              state_d   = S_IDLE;
              frame_end = 1'b1;
            end
          end
        end
        S_CHK: begin
          state_d   = S_IDLE;
          frame_end = 1'b1;
          chk_ok    = (rx_data == chk_q);
        end
        default: state_d = S_IDLE;
      endcase
    end

    if (timeout) begin
      state_d = S_IDLE;
      stage_d = '{default: '0};
      mask_d  = '0;
    end
  end

  // Frame validation; checksum failure masks every other error.
  always_comb begin
    end_sum = {1'b0, addr_d} + {2'b00, len_d[7:1]};
    code    = RC_OK;
    if (!chk_ok) begin
      code = RC_CHK;
    end else if (cmd_d == 8'h01) begin
      if (len_d[0] || len_d == 8'd0 || end_sum > 9'(NUM_PAR)) code = RC_RANGE;
    end else if (cmd_d == 8'h02) begin
      if (len_d != 8'd1) code = RC_RANGE;
      else if (sel_stage_d >= 8'(NUM_STRAT)) code = RC_STRAT;
    end else if (cmd_d == 8'h03) begin
      if (len_d != 8'd0) code = RC_RANGE;
    end else begin
      code = RC_CMD;
    end
  end

  // Shadow bank, commit and response; apply copies the pre-edge shadow.
  always_comb begin
    shadow_d     = shadow_q;
    shadow_sel_d = shadow_sel_q;
    act_sel_d    = act_sel_q;
    act_par_d    = act_par_q;
    pending_d    = pending_q;
    apply        = pending_q & fsm_idle;
    commit_d     = apply;
    resp_valid_d = frame_end | timeout;
    resp_code_d  = resp_code_q;

    if (apply) begin
      act_sel_d = shadow_sel_q;
      for (int k = 0; k < NUM_PAR; k++) act_par_d[k*PAR_W +: PAR_W] = shadow_q[k];
      pending_d = 1'b0;
    end

    if (frame_end) begin
      resp_code_d = code;
      if (code == RC_OK) begin
        case (cmd_d)
          8'h01: begin
            for (int k = 0; k < NUM_PAR; k++) begin
              for (int j = 0; j < NUM_PAR; j++) begin
                if (({1'b0, addr_d} + 9'(j) == 9'(k)) &&
                    (8'(j) < {1'b0, len_d[7:1]}) && mask_d[j]) begin
                  shadow_d[k] = stage_d[j];
                end
              end
            end
          end
          8'h02:   shadow_sel_d = sel_stage_d;
          8'h03:   pending_d = 1'b1;
          default: ;
        endcase
      end
    end else if (timeout) begin
      resp_code_d = RC_TIMEOUT;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q      <= S_IDLE;
      cmd_q        <= '0;
      addr_q       <= '0;
      len_q        <= '0;
      cnt_q        <= '0;
      chk_q        <= '0;
      sel_stage_q  <= '0;
      to_cnt_q     <= '0;
      mask_q       <= '0;
      shadow_sel_q <= '0;
      act_sel_q    <= '0;
      act_par_q    <= '0;
      commit_q     <= 1'b0;
      pending_q    <= 1'b0;
      resp_valid_q <= 1'b0;
      resp_code_q  <= '0;
      for (int k = 0; k < NUM_PAR; k++) begin
        stage_q[k]  <= '0;
        shadow_q[k] <= '0;
      end
    end else begin
      state_q      <= state_d;
      cmd_q        <= cmd_d;
      addr_q       <= addr_d;
      len_q        <= len_d;
      cnt_q        <= cnt_d;
      chk_q        <= chk_d;
      sel_stage_q  <= sel_stage_d;
      to_cnt_q     <= to_cnt_d;
      mask_q       <= mask_d;
      shadow_sel_q <= shadow_sel_d;
      act_sel_q    <= act_sel_d;
      act_par_q    <= act_par_d;
      commit_q     <= commit_d;
      pending_q    <= pending_d;
      resp_valid_q <= resp_valid_d;
      resp_code_q  <= resp_code_d;
      for (int k = 0; k < NUM_PAR; k++) begin
        stage_q[k]  <= stage_d[k];
        shadow_q[k] <= shadow_d[k];
      end
    end
  end

  assign strategy_sel = act_sel_q;
  assign par_flat     = act_par_q;
  assign commit_pulse = commit_q;
  assign pending      = pending_q;
  assign resp_valid   = resp_valid_q;
  assign resp_code    = resp_code_q;

endmodule

// File: tb/tb_strategy_cfg_loader.sv
// Bench for strategy_cfg_loader: frame-level reference model checked every cycle,
// directed scenarios with literal expectations, then randomized traffic.
module tb_strategy_cfg_loader;
  localparam int NUM_PAR   = 8;
  localparam int PAR_W     = 16;
  localparam int NUM_STRAT = 5;
  localparam int TB_TO     = 300;
`ifdef STRATEGY_CFG_CHECKSUM_EN
  localparam int CSN = 1;
`else
  localparam int CSN = 0;
`endif

  logic                     clock    = 1'b0;
  logic                     reset    = 1'b0;
  logic [7:0]               rx_data  = 8'h00;
  logic                     rx_valid = 1'b0;
  logic                     fsm_idle = 1'b0;
  logic [7:0]               strategy_sel;
  logic [NUM_PAR*PAR_W-1:0] par_flat;
  logic                     commit_pulse;
  logic                     pending;
  logic                     resp_valid;
  logic [7:0]               resp_code;

  strategy_cfg_loader #(
    .NUM_PAR(NUM_PAR), .PAR_W(PAR_W), .NUM_STRAT(NUM_STRAT), .TIMEOUT_CYC(TB_TO)
  ) dut (
    .clock(clock), .reset(reset), .rx_data(rx_data), .rx_valid(rx_valid),
    .fsm_idle(fsm_idle), .strategy_sel(strategy_sel), .par_flat(par_flat),
    .commit_pulse(commit_pulse), .pending(pending), .resp_valid(resp_valid),
    .resp_code(resp_code)
  );

  always #5 clock = ~clock;

  int  checks = 0;
  int  errors = 0;
  bit  started = 1'b0;
  bit  rand_idle = 1'b0;

  // Reference model state
  logic [7:0]  m_sel, sh_sel;
  logic [15:0] m_par [NUM_PAR];
  logic [15:0] sh_par [NUM_PAR];
  bit          m_pending, in_frame;
  int          silence;
  logic [7:0]  frame[$];
  logic        exp_rv, exp_cp;
  logic [7:0]  exp_code;

  logic [7:0]  obs_codes[$];
  int          commit_cnt = 0;
  logic [7:0]  pl[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_sel = '0; sh_sel = '0; m_pending = 1'b0; in_frame = 1'b0; silence = 0;
    exp_rv = 1'b0; exp_cp = 1'b0; exp_code = '0;
    frame.delete();
    for (int k = 0; k < NUM_PAR; k++) begin
      m_par[k] = '0; sh_par[k] = '0;
    end
  endtask

  task automatic model_frame_done();
    int cmd, addr, len, xr;
    logic [7:0] code;
    cmd  = int'(frame[0]);
    addr = int'(frame[1]);
    len  = int'(frame[2]);
    xr   = cmd ^ addr ^ len;
    for (int i = 0; i < len; i++) xr = xr ^ int'(frame[3+i]);
    code = 8'h00;
    if (CSN == 1 && int'(frame[3+len]) != xr) code = 8'h01;
    else if (cmd == 1) begin
      if ((len % 2) != 0 || len == 0 || addr + len / 2 > NUM_PAR) code = 8'h03;
    end else if (cmd == 2) begin
      if (len != 1) code = 8'h03;
      else if (int'(frame[3]) >= NUM_STRAT) code = 8'h05;
    end else if (cmd == 3) begin
      if (len != 0) code = 8'h03;
    end else code = 8'h02;
    if (code == 8'h00) begin
      if (cmd == 1) for (int j = 0; j < len / 2; j++) sh_par[addr+j] = {frame[3+2*j], frame[4+2*j]};
      if (cmd == 2) sh_sel = frame[3];
      if (cmd == 3) m_pending = 1'b1;
    end
    exp_rv   = 1'b1;
    exp_code = code;
  endtask

  task automatic model_step();
    exp_rv = 1'b0;
    exp_cp = 1'b0;
    if (m_pending && fsm_idle) begin
      m_sel = sh_sel;
      for (int k = 0; k < NUM_PAR; k++) m_par[k] = sh_par[k];
      exp_cp    = 1'b1;
      m_pending = 1'b0;
    end
    if (rx_valid) begin
      silence = 0;
      if (!in_frame) begin
        if (rx_data == 8'hA5) begin
          in_frame = 1'b1;
          frame.delete();
        end
      end else begin
        frame.push_back(rx_data);
        if (frame.size() >= 3 && frame.size() == 3 + int'(frame[2]) + CSN) begin
          model_frame_done();
          in_frame = 1'b0;
        end
      end
    end else if (in_frame) begin
      silence++;
      if (silence == TB_TO) begin
        in_frame = 1'b0;
        exp_rv   = 1'b1;
        exp_code = 8'h04;
      end
    end
  endtask

  initial begin
    model_reset();
    forever begin
      @(posedge clock or posedge reset);
      if (reset) model_reset();
      else model_step();
    end
  end

  // Per-cycle comparison against the model, sampled on the falling edge
  initial begin
    forever begin
      @(negedge clock);
      if (started && !reset) begin
        check("strategy_sel", 32'(strategy_sel), 32'(m_sel));
        for (int k = 0; k < NUM_PAR; k++)
          check($sformatf("par_word%0d", k), 32'(par_flat[k*PAR_W +: PAR_W]), 32'(m_par[k]));
        check("pending", 32'(pending), 32'(m_pending));
        check("commit_pulse", 32'(commit_pulse), 32'(exp_cp));
        check("resp_valid", 32'(resp_valid), 32'(exp_rv));
        if (exp_rv) check("resp_code", 32'(resp_code), 32'(exp_code));
        if (resp_valid) obs_codes.push_back(resp_code);
        if (commit_pulse) commit_cnt++;
      end
    end
  end

  task automatic tick();
    @(negedge clock);
    if (rand_idle) fsm_idle = ($urandom_range(0, 2) == 0);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      tick();
      rx_valid = 1'b0;
    end
  endtask

  task automatic send_byte(input logic [7:0] b);
    tick();
    rx_valid = 1'b1;
    rx_data  = b;
  endtask

  // Payload comes from pl (random bytes if pl is short); CHK follows the XOR rule
  task automatic send_frame(input logic [7:0] cmd, input logic [7:0] addr, input logic [7:0] len,
                            input bit bad_chk, input int gap_max, input int stall_at);
    logic [7:0] bytes[$];
    logic [7:0] x;
    logic [7:0] d;
    x = cmd ^ addr ^ len;
    bytes = '{8'hA5, cmd, addr, len};
    for (int i = 0; i < int'(len); i++) begin
      d = (i < pl.size()) ? pl[i] : 8'($urandom);
      bytes.push_back(d);
      x = x ^ d;
    end
    if (CSN == 1) bytes.push_back(x ^ {7'b0, bad_chk});
    foreach (bytes[i]) begin
      if (i == stall_at) idle(TB_TO - 2 + int'($urandom_range(0, 4)));
      else if (i > 0 && gap_max > 0) idle(int'($urandom_range(0, gap_max)));
      send_byte(bytes[i]);
    end
    idle(1);
  endtask

  int n0, c0;

  initial begin
    #1 reset = 1'b1;
    repeat (3) @(negedge clock);
    reset   = 1'b0;
    started = 1'b1;

    // Reset state, quiet link
    n0 = obs_codes.size();
    idle(10);
    check("rst_sel", 32'(strategy_sel), 32'h0);
    check("rst_par_nonzero", 32'(par_flat != '0), 32'h0);
    check("rst_pending", 32'(pending), 32'h0);
    check("rst_resp_count", 32'(obs_codes.size() - n0), 32'h0);

    // Write words 2..3 then commit with the FSM idle
    fsm_idle = 1'b1;
    n0 = obs_codes.size(); c0 = commit_cnt;
    pl = '{8'h12, 8'h34, 8'hAB, 8'hCD};
    send_frame(8'h01, 8'h02, 8'h04, 1'b0, 0, -1);
    pl.delete();
    send_frame(8'h03, 8'h00, 8'h00, 1'b0, 0, -1);
    idle(5);
    check("wr_resp_count", 32'(obs_codes.size() - n0), 32'd2);
    check("wr_resp0", 32'(obs_codes[n0]), 32'h00);
    check("wr_resp1", 32'(obs_codes[n0+1]), 32'h00);
    check("wr_word2", 32'(par_flat[2*PAR_W +: PAR_W]), 32'h1234);
    check("wr_word3", 32'(par_flat[3*PAR_W +: PAR_W]), 32'hABCD);
    check("wr_word0", 32'(par_flat[0 +: PAR_W]), 32'h0);
    check("wr_commit_once", 32'(commit_cnt - c0), 32'd1);

    // Strategy 7 is out of range
    n0 = obs_codes.size();
    pl = '{8'h07};
    send_frame(8'h02, 8'h00, 8'h01, 1'b0, 0, -1);
    pl.delete();
    send_frame(8'h03, 8'h00, 8'h00, 1'b0, 0, -1);
    idle(5);
    check("strat_bad_code", 32'(obs_codes[n0]), 32'h05);
    check("strat_commit_code", 32'(obs_codes[n0+1]), 32'h00);
    check("strat_sel_kept", 32'(strategy_sel), 32'h0);

    // Commit held off while the FSM is busy
    fsm_idle = 1'b0;
    pl = '{8'h03};
    send_frame(8'h02, 8'h00, 8'h01, 1'b0, 0, -1);
    pl.delete();
    send_frame(8'h03, 8'h00, 8'h00, 1'b0, 0, -1);
    idle(3);
    check("busy_pending", 32'(pending), 32'h1);
    c0 = commit_cnt;
    idle(50);
    check("busy_no_pulse", 32'(commit_cnt - c0), 32'd0);
    check("busy_sel_old", 32'(strategy_sel), 32'h0);
    tick();
    fsm_idle = 1'b1;
    tick();
    check("apply_sel", 32'(strategy_sel), 32'h3);
    check("apply_pulse", 32'(commit_pulse), 32'h1);
    check("apply_pending_clr", 32'(pending), 32'h0);
    tick();
    check("apply_pulse_one", 32'(commit_pulse), 32'h0);

    // Corrupted checksum on a write to word 0
    n0 = obs_codes.size();
    pl = '{8'h55, 8'h66};
    send_frame(8'h01, 8'h00, 8'h02, 1'b1, 0, -1);
    pl.delete();
    send_frame(8'h03, 8'h00, 8'h00, 1'b0, 0, -1);
    idle(5);
`ifdef STRATEGY_CFG_CHECKSUM_EN
    check("badchk_code", 32'(obs_codes[n0]), 32'h01);
    check("badchk_word0", 32'(par_flat[0 +: PAR_W]), 32'h0);
`else
    check("nochk_code", 32'(obs_codes[n0]), 32'h00);
    check("nochk_word0", 32'(par_flat[0 +: PAR_W]), 32'h5566);
`endif

    // Inter-byte timeout, then a clean frame
    n0 = obs_codes.size();
    send_byte(8'hA5); send_byte(8'h01); send_byte(8'h00);
    idle(TB_TO + 5);
    check("to_resp_count", 32'(obs_codes.size() - n0), 32'd1);
    check("to_code", 32'(obs_codes[n0]), 32'h04);
    pl = '{8'h00, 8'h01};
    send_frame(8'h01, 8'h07, 8'h02, 1'b0, 0, -1);
    idle(3);
    check("after_to_code", 32'(obs_codes[n0+1]), 32'h00);

    // Randomized traffic
    rand_idle = 1'b1;
    for (int f = 0; f < 300; f++) begin
      int r, sel;
      logic [7:0] cmd, addr, len, b;
      r = int'($urandom_range(0, 99));
      if (r < 4) begin
        tick();
        rx_valid = 1'b0;
        #1 reset = 1'b1;
        #2 reset = 1'b0;
      end else if (r < 12) begin
        b = 8'($urandom);
        if (b == 8'hA5) b = 8'h5A;
        send_byte(b);
        idle(1);
      end else begin
        sel  = int'($urandom_range(0, 9));
        addr = 8'($urandom_range(0, 9));
        if (sel < 4) begin
          cmd = 8'h01;
          len = ($urandom_range(0, 4) == 0) ? 8'($urandom_range(0, 40))
                                            : 8'(2 * $urandom_range(1, 8));
        end else if (sel < 6) begin
          cmd = 8'h02;
          len = ($urandom_range(0, 5) == 0) ? 8'($urandom_range(0, 3)) : 8'h01;
        end else if (sel < 8) begin
          cmd = 8'h03;
          len = ($urandom_range(0, 5) == 0) ? 8'($urandom_range(0, 3)) : 8'h00;
        end else begin
          cmd = 8'($urandom);
          len = 8'($urandom_range(0, 6));
        end
        pl.delete();
        if (cmd == 8'h02) pl.push_back(8'($urandom_range(0, 7)));
        send_frame(cmd, addr, len, ($urandom_range(0, 9) == 0), int'($urandom_range(0, 3)),
                   ($urandom_range(0, 39) == 0) ? int'($urandom_range(1, int'(len) + 3)) : -1);
        idle(int'($urandom_range(0, 4)));
      end
    end
    idle(10);
    rand_idle = 1'b0;

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
